operand_stage: RTL and testbench

Decode-side operand stage of the pipelined CPU: applies forwarding selects to register-file operands, owns the ID/EX pipeline register, and detects load-use hazards. Sits directly upstream of the EX stage and consumes the DaSEL/DbSEL outputs of the forwarding unit. It also generates the stall that freezes the PC and the IF/ID register, and inserts bubbles on stall or branch flush.

---
 rtl/operand_stage.sv | 167 ++++++++++++++++
 tb/tb_operand_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stage.sv
// Decode-side operand stage: forwarding muxes, ID/EX register and load-use stall FSM.
// Optional build macro OPERAND_STALL_CNT_EN adds a 32-bit stall-cycle counter on stall_cnt.
module operand_stage #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [4:0]        Aa,
  input  logic [4:0]        Ab,
  input  logic [4:0]        Aw,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [WIDTH-1:0]  Da_rf,
  input  logic [WIDTH-1:0]  Db_rf,
  input  logic [WIDTH-1:0]  imm_in,
  input  logic [1:0]        DaSEL,
  input  logic [1:0]        DbSEL,
  input  logic [WIDTH-1:0]  alu_ex,
  input  logic [WIDTH-1:0]  res_mem,
  input  logic              flush,
  output logic              stall,
  output logic              valid_ex,
  output logic [WIDTH-1:0]  Da_ex,
  output logic [WIDTH-1:0]  Db_ex,
  output logic [WIDTH-1:0]  imm_ex,
  output logic [4:0]        Aw_ex,
  output logic              reg_write_ex,
  output logic              mem_read_ex,
  output logic [CTRL_W-1:0] ctrl_ex
`ifdef OPERAND_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic {
    S_RUN,
    S_STALL
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic [4:0]        aw;
    logic [CTRL_W-1:0] ctrl;
    logic [WIDTH-1:0]  da;
    logic [WIDTH-1:0]  db;
    logic [WIDTH-1:0]  imm;
  } idex_t;

  // X31 is never forwarded, so a bubble targeting it is inert downstream.
  localparam idex_t BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    aw:        5'd31,
    ctrl:      '0,
    da:        '0,
    db:        '0,
    imm:       '0
  };

  state_t state_q, state_d;
  idex_t  idex_q, idex_d;
  idex_t  decode;
  logic [WIDTH-1:0] da_sel, db_sel;
  logic lu;
  logic stall_c;

  always_comb begin
    unique case (DaSEL)
      2'b00:   da_sel = alu_ex;
      2'b01:   da_sel = res_mem;
      default: da_sel = Da_rf;
    endcase
    unique case (DbSEL)
      2'b00:   db_sel = alu_ex;
      2'b01:   db_sel = res_mem;
      default: db_sel = Db_rf;
    endcase
  end

  always_comb begin
    decode = '{
      valid:     1'b1,
      reg_write: reg_write_in,
      mem_read:  mem_read_in,
      aw:        Aw,
      ctrl:      ctrl_in,
      da:        da_sel,
      db:        db_sel,
      imm:       imm_in
    };
  end

  // The Ab compare is applied even for formats that do not read Ab.
  assign lu = in_valid & idex_q.valid & idex_q.mem_read & (idex_q.aw != 5'd31) &
              ((Aa == idex_q.aw) | (Ab == idex_q.aw));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idex_d  = BUBBLE;
    stall_c = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (flush) begin
          idex_d = BUBBLE;
        end else if (lu) begin
          stall_c = 1'b1;
          state_d = S_STALL;
        end else begin
          idex_d = in_valid ? decode : BUBBLE;
        end
      end
      S_STALL: begin
        state_d = S_RUN;
        if (!flush) begin
          idex_d = in_valid ? decode : BUBBLE;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign stall = stall_c & reset_n;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset_n) begin
      state_q <= S_RUN;
      idex_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  assign valid_ex     = idex_q.valid;
  assign reg_write_ex = idex_q.reg_write;
  assign mem_read_ex  = idex_q.mem_read;
  assign Aw_ex        = idex_q.aw;
  assign ctrl_ex      = idex_q.ctrl;
  assign Da_ex        = idex_q.da;
  assign Db_ex        = idex_q.db;
  assign imm_ex       = idex_q.imm;

`ifdef OPERAND_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Directed table-driven bench for operand_stage: forwarding, load-use stall, flush, reset.
module tb_operand_stage;

  localparam int WIDTH  = 64;
  localparam int CTRL_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [4:0]        Aa, Ab, Aw;
  logic              reg_write_in, mem_read_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [WIDTH-1:0]  Da_rf, Db_rf, imm_in, alu_ex, res_mem;
  logic [1:0]        DaSEL, DbSEL;
  logic              flush;
  logic              stall, valid_ex, reg_write_ex, mem_read_ex;
  logic [WIDTH-1:0]  Da_ex, Db_ex, imm_ex;
  logic [4:0]        Aw_ex;
  logic [CTRL_W-1:0] ctrl_ex;
`ifdef OPERAND_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_stage #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .Aa           (Aa),
    .Ab           (Ab),
    .Aw           (Aw),
    .reg_write_in (reg_write_in),
    .mem_read_in  (mem_read_in),
    .ctrl_in      (ctrl_in),
    .Da_rf        (Da_rf),
    .Db_rf        (Db_rf),
    .imm_in       (imm_in),
    .DaSEL        (DaSEL),
    .DbSEL        (DbSEL),
    .alu_ex       (alu_ex),
    .res_mem      (res_mem),
    .flush        (flush),
    .stall        (stall),
    .valid_ex     (valid_ex),
    .Da_ex        (Da_ex),
    .Db_ex        (Db_ex),
    .imm_ex       (imm_ex),
    .Aw_ex        (Aw_ex),
    .reg_write_ex (reg_write_ex),
    .mem_read_ex  (mem_read_ex),
    .ctrl_ex      (ctrl_ex)
`ifdef OPERAND_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  typedef struct {
    logic        iv;
    logic [4:0]  aa, ab, aw;
    logic        rw, mr;
    logic [1:0]  dasel, dbsel;
    logic [63:0] mem;
    logic        fl;
    logic        e_stall, e_valid;
    logic [4:0]  e_aw;
    logic        e_rw, e_mr;
    logic [63:0] e_da, e_db;
  } vec_t;

  function automatic vec_t v(input logic iv, input logic [4:0] aa, input logic [4:0] ab,
                             input logic [4:0] aw, input logic rw, input logic mr,
                             input logic [1:0] dasel, input logic [1:0] dbsel,
                             input logic [63:0] mem, input logic fl,
                             input logic e_stall, input logic e_valid, input logic [4:0] e_aw,
                             input logic e_rw, input logic e_mr,
                             input logic [63:0] e_da, input logic [63:0] e_db);
    vec_t r;
    r.iv = iv; r.aa = aa; r.ab = ab; r.aw = aw; r.rw = rw; r.mr = mr;
    r.dasel = dasel; r.dbsel = dbsel; r.mem = mem; r.fl = fl;
    r.e_stall = e_stall; r.e_valid = e_valid; r.e_aw = e_aw;
    r.e_rw = e_rw; r.e_mr = e_mr; r.e_da = e_da; r.e_db = e_db;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] aa, input logic [4:0] ab,
                       input logic [4:0] aw, input logic rw, input logic mr,
                       input logic [1:0] dasel, input logic [1:0] dbsel,
                       input logic [63:0] mem, input logic fl);
    in_valid = iv; Aa = aa; Ab = ab; Aw = aw;
    reg_write_in = rw; mem_read_in = mr;
    ctrl_in = 8'hA0 | {3'b000, aw};
    DaSEL = dasel; DbSEL = dbsel; res_mem = mem; flush = fl;
  endtask

  vec_t tbl[21];
  int   exp_stalls;

  initial begin
    Da_rf = 64'd1; Db_rf = 64'd10; alu_ex = 64'd2; imm_in = 64'd7;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd2, 2'd2, 64'd3, 1'b0);
    reset_n = 1'b0;

    // iv aa ab aw rw mr dasel dbsel mem fl | stall valid aw rw mr da db
    tbl[0]  = v(1, 1, 2, 3,  1, 0, 0, 2, 3, 0,      0, 1, 3,  1, 0, 2, 10);
    tbl[1]  = v(1, 1, 2, 3,  1, 0, 1, 0, 3, 0,      0, 1, 3,  1, 0, 3, 2);
    tbl[2]  = v(1, 1, 2, 3,  1, 0, 2, 1, 3, 0,      0, 1, 3,  1, 0, 1, 3);
    tbl[3]  = v(1, 1, 2, 3,  1, 0, 3, 3, 3, 0,      0, 1, 3,  1, 0, 1, 10);
    tbl[4]  = v(1, 1, 2, 5,  1, 1, 2, 2, 3, 0,      0, 1, 5,  1, 1, 1, 10);
    tbl[5]  = v(1, 5, 6, 7,  1, 0, 0, 0, 3, 0,      1, 0, 31, 0, 0, 0, 0);
    tbl[6]  = v(1, 5, 6, 7,  1, 0, 1, 2, 'hAB, 0,   0, 1, 7,  1, 0, 'hAB, 10);
    tbl[7]  = v(1, 1, 2, 31, 1, 1, 2, 2, 3, 0,      0, 1, 31, 1, 1, 1, 10);
    tbl[8]  = v(1, 31, 0, 4, 1, 0, 2, 2, 3, 0,      0, 1, 4,  1, 0, 1, 10);
    tbl[9]  = v(1, 1, 2, 8,  1, 1, 2, 2, 3, 0,      0, 1, 8,  1, 1, 1, 10);
    tbl[10] = v(1, 8, 2, 11, 1, 0, 2, 2, 3, 1,      0, 0, 31, 0, 0, 0, 0);
    tbl[11] = v(1, 1, 2, 9,  1, 1, 2, 2, 3, 0,      0, 1, 9,  1, 1, 1, 10);
    tbl[12] = v(1, 0, 9, 10, 1, 0, 2, 2, 3, 0,      1, 0, 31, 0, 0, 0, 0);
    tbl[13] = v(1, 0, 9, 10, 1, 0, 2, 2, 3, 1,      0, 0, 31, 0, 0, 0, 0);
    tbl[14] = v(1, 1, 2, 12, 1, 1, 2, 2, 3, 0,      0, 1, 12, 1, 1, 1, 10);
    tbl[15] = v(0, 12, 2, 3, 1, 0, 2, 2, 3, 0,      0, 0, 31, 0, 0, 0, 0);
    tbl[16] = v(1, 1, 2, 13, 1, 1, 2, 2, 3, 0,      0, 1, 13, 1, 1, 1, 10);
    tbl[17] = v(1, 13, 2, 14, 1, 1, 2, 2, 3, 0,     1, 0, 31, 0, 0, 0, 0);
    tbl[18] = v(1, 13, 2, 14, 1, 1, 2, 2, 3, 0,     0, 1, 14, 1, 1, 1, 10);
    tbl[19] = v(1, 14, 2, 15, 1, 0, 2, 2, 3, 0,     1, 0, 31, 0, 0, 0, 0);
    tbl[20] = v(1, 14, 2, 15, 1, 0, 1, 2, 'hAB, 0,  0, 1, 15, 1, 0, 'hAB, 10);

    // Reset held for two edges with a would-be load-use decode on the inputs.
    drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 2'd2, 2'd2, 64'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_valid", {63'd0, valid_ex}, 64'd0);
    check("reset_aw", {59'd0, Aw_ex}, 64'd31);
    check("reset_mem_read", {63'd0, mem_read_ex}, 64'd0);
    check("reset_da", Da_ex, 64'd0);
`ifdef OPERAND_STALL_CNT_EN
    check("reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    reset_n = 1'b1;

    exp_stalls = 0;
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].iv, tbl[i].aa, tbl[i].ab, tbl[i].aw, tbl[i].rw, tbl[i].mr,
            tbl[i].dasel, tbl[i].dbsel, tbl[i].mem, tbl[i].fl);
      #2;
      check($sformatf("v%0d_stall", i), {63'd0, stall}, {63'd0, tbl[i].e_stall});
      if (tbl[i].e_stall) exp_stalls++;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {63'd0, valid_ex}, {63'd0, tbl[i].e_valid});
      check($sformatf("v%0d_aw", i), {59'd0, Aw_ex}, {59'd0, tbl[i].e_aw});
      check($sformatf("v%0d_reg_write", i), {63'd0, reg_write_ex}, {63'd0, tbl[i].e_rw});
      check($sformatf("v%0d_mem_read", i), {63'd0, mem_read_ex}, {63'd0, tbl[i].e_mr});
      check($sformatf("v%0d_da", i), Da_ex, tbl[i].e_da);
      check($sformatf("v%0d_db", i), Db_ex, tbl[i].e_db);
      check($sformatf("v%0d_imm", i), imm_ex, tbl[i].e_valid ? 64'd7 : 64'd0);
      check($sformatf("v%0d_ctrl", i), {56'd0, ctrl_ex},
            tbl[i].e_valid ? {56'd0, 8'hA0 | {3'b000, tbl[i].e_aw}} : 64'd0);
    end
`ifdef OPERAND_STALL_CNT_EN
    check("stall_cnt_total", {32'd0, stall_cnt}, 64'(exp_stalls));
`endif

    // Reset arriving while a load-use stall is pending clears everything.
    drive(1'b1, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 2'd2, 2'd2, 64'd3, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd20, 5'd2, 5'd21, 1'b1, 1'b0, 2'd2, 2'd2, 64'd3, 1'b0);
    #1;
    check("mid_lu_stall", {63'd0, stall}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_forces_stall_low", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    check("mid_reset_valid", {63'd0, valid_ex}, 64'd0);
    check("mid_reset_aw", {59'd0, Aw_ex}, 64'd31);
`ifdef OPERAND_STALL_CNT_EN
    check("mid_reset_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    reset_n = 1'b1;
    #1;
    check("post_reset_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    check("post_reset_valid", {63'd0, valid_ex}, 64'd1);
    check("post_reset_aw", {59'd0, Aw_ex}, 64'd21);

    // Reset taken in the STALL state itself must return to RUN with no extra stall.
    drive(1'b1, 5'd1, 5'd2, 5'd22, 1'b1, 1'b1, 2'd2, 2'd2, 64'd3, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd22, 5'd2, 5'd23, 1'b1, 1'b0, 2'd2, 2'd2, 64'd3, 1'b0);
    @(posedge clk);
    #1;
    check("stall_state_entered", {63'd0, valid_ex}, 64'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 5'd22, 5'd2, 5'd24, 1'b1, 1'b1, 2'd2, 2'd2, 64'd3, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 5'd24, 5'd2, 5'd25, 1'b1, 1'b0, 2'd2, 2'd2, 64'd3, 1'b0);
    #1;
    check("run_after_stall_reset", {63'd0, stall}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
